pingpong_mch_frame_buffer: RTL and testbench
============================================

Name: pingpong_mch_frame_buffer

Overview:
Parametrised successor to the single-channel ping-pong sample RAM. It captures N_CH parallel channels per sample strobe into two banks of DEPTH frames each. Each completed bank is handed to a reader through an explicit ownership/release handshake. When the reader holds a bank too long, the block reports and counts dropped frames instead of silently overwriting data. It sits between the multi-mic I2S capture front end and the downstream processing/UART readout.

Parameters:
N_CH, 4, number of channels written per sample strobe (≥1)
DATA_W, 24, bits per sample
DEPTH, 512, frames per bank (power of two, ≥2)
ADDR_W, $clog2(DEPTH), frame address width
CH_W, (N_CH>1 ? $clog2(N_CH) : 1), channel select width
DROP_W, 16, width of dropped-frame counter

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
enable_i  in  1  capture enable; when low, samples are ignored and not counted as dropped
sample_i  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
sample_valid_i  in  1  one-cycle strobe, one frame per strobe
rd_en_i  in  1  read request from the owned bank
rd_ch_i  in  CH_W  read channel select
rd_addr_i  in  ADDR_W  read frame index
rd_data_o  out  DATA_W  read data
rd_valid_o  out  1  rd_data_o valid
release_i  in  1  reader returns the owned bank
buffer_ready_o  out  1  one-cycle pulse on bank handoff
ready_bank_o  out  1  index of the bank owned by the reader
owned_o  out  1  reader currently owns a bank
overflow_o  out  1  sticky: at least one frame dropped
clear_overflow_i  in  1  clears overflow_o and drop_cnt_o
drop_cnt_o  out  DROP_W  dropped frames, saturating
wr_ptr_o  out  ADDR_W  next write frame index

Behaviour:
- Storage: one RAM per channel, 2*DEPTH x DATA_W, addressed {bank, frame}.
- Reset state (async, rst_i=1): state FILL, wr_bank=0, wr_ptr=0, owned=0, ready_bank_o=0, buffer_ready_o=0, rd_valid_o=0, rd_data_o=0, overflow_o=0, drop_cnt_o=0. RAM contents are undefined.
- Accepted write = sample_valid_i & enable_i. It writes all N_CH channels at {wr_bank, wr_ptr} in the same cycle.
- State FILL:
  - An accepted write with wr_ptr<DEPTH-1 increments wr_ptr.
  - An accepted write with wr_ptr==DEPTH-1 completes the bank:
    - If owned==0, or release_i is asserted this cycle: handoff.
    - Otherwise: go to WAIT; wr_ptr stays DEPTH-1.
- Handoff (registered, visible next cycle):
  - ready_bank_o <= wr_bank; owned <= 1; buffer_ready_o pulses 1 cycle.
  - wr_bank <= ~wr_bank; wr_ptr <= 0.
- State WAIT: the completed bank is retained untouched.
  - Each accepted write is dropped: overflow_o <= 1; drop_cnt_o increments and saturates at all-ones.
  - release_i: handoff of the retained bank, return to FILL. A sample accepted in that same cycle is written to frame 0 of the freed bank, wr_ptr <= 1, and is not counted as dropped.
- release_i in FILL clears owned (unless it coincides with a handoff, in which case owned stays 1). release_i with owned==0 is ignored.
- Read path:
  - rd_en_i & owned: rd_data_o = RAM_ch[{ready_bank_o, rd_addr_i}] one cycle later, rd_valid_o=1 for that cycle.
  - rd_en_i with owned==0: rd_valid_o stays 0 and rd_data_o holds its value.
  - rd_ch_i ≥ N_CH: rd_data_o=0 with rd_valid_o=1.
  - A read in the same cycle as release_i is still serviced from the released bank.
- clear_overflow_i clears overflow_o and drop_cnt_o. If a drop occurs in the same cycle, clear wins, then overflow_o=1 and drop_cnt_o=1 the next cycle.
- enable_i low: wr_ptr and state are held, and writes resume at the held wr_ptr.
- The reader never sees the bank currently being written.

Test Plan:
(Use N_CH=2, DATA_W=24, DEPTH=8.)
- Reset, then 8 strobes, ch0=k, ch1=0x100+k (k=0..7) -> buffer_ready_o pulses once, ready_bank_o=0, owned_o=1, wr_ptr_o=0; reading ch1 addr 5 returns 0x000105 one cycle after rd_en_i.
- Fill bank 1 (8 more strobes) without release, then 3 further strobes -> no second pulse, overflow_o=1, drop_cnt_o=3, wr_ptr_o=7; bank 0 readback unchanged.
- From that WAIT state, assert release_i together with strobe value 0xAA -> buffer_ready_o pulses, ready_bank_o=1, wr_ptr_o=1; after the next handoff, frame 0 of bank 0 reads 0xAA.
- Release in the same cycle as the 8th write of the next bank -> direct handoff, no overflow, drop_cnt_o unchanged.
- rd_en_i before the first handoff -> rd_valid_o stays 0; rd_ch_i=3 while owned -> rd_data_o=0, rd_valid_o=1.
- Assert rst_i mid-fill at wr_ptr=4 with owned=1 -> all outputs return to reset values immediately; the next 8 strobes hand off bank 0.

Source files
------------

// File: rtl/pingpong_mch_frame_buffer.sv
// pingpong_mch_frame_buffer: multi-channel ping-pong frame capture with reader ownership handshake and drop accounting
module pingpong_mch_frame_buffer #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = (N_CH > 1 ? $clog2(N_CH) : 1),
  parameter int DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [N_CH*DATA_W-1:0]   sample_i,
  input  logic                     sample_valid_i,
  input  logic                     rd_en_i,
  input  logic [CH_W-1:0]          rd_ch_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     release_i,
  output logic                     buffer_ready_o,
  output logic                     ready_bank_o,
  output logic                     owned_o,
  output logic                     overflow_o,
  input  logic                     clear_overflow_i,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic [ADDR_W-1:0]        wr_ptr_o
);
  typedef enum logic {S_FILL, S_WAIT} state_t;
  state_t r_state, w_state_nx;
  logic r_wr_bank, r_owned, r_ready_bank, r_buffer_ready, r_overflow, r_rd_valid, r_rd_oob;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nx;
  logic [DROP_W-1:0] r_drop;
  logic [CH_W-1:0] r_rd_ch;
  logic w_acc, w_last, w_handoff, w_to_wait, w_we, w_drop, w_rd, w_oob;
  logic [ADDR_W:0] w_waddr;
  logic [N_CH*DATA_W-1:0] w_q;
  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_FILL;
    else r_state <= w_state_nx;
  end
  // next state: a full bank that the reader still holds parks us in WAIT until release
  always_comb begin
    w_state_nx = (r_state == S_FILL) ? (w_to_wait ? S_WAIT : S_FILL) : (release_i ? S_FILL : S_WAIT);
  end
  // datapath controls; in WAIT the reader always owns the other bank, so release_i alone frees it
  always_comb begin
    w_acc = sample_valid_i & enable_i;
    w_last = w_acc & (r_wr_ptr == ADDR_W'(DEPTH - 1));
    w_handoff = (r_state == S_FILL) ? (w_last & (~r_owned | release_i)) : release_i;
    w_to_wait = (r_state == S_FILL) & w_last & r_owned & ~release_i;
    w_we = w_acc & ((r_state == S_FILL) | release_i);
    w_drop = (r_state == S_WAIT) & w_acc & ~release_i;
    w_waddr = (r_state == S_FILL) ? {r_wr_bank, r_wr_ptr} : {~r_wr_bank, ADDR_W'(0)};
    w_wr_ptr_nx = (r_state == S_WAIT) ? (release_i ? ADDR_W'(w_acc) : r_wr_ptr)
                : w_handoff ? '0
                : (w_acc & ~w_last) ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
    w_rd = rd_en_i & r_owned;
    w_oob = 32'(rd_ch_i) >= 32'(N_CH);
  end
  // bank handoff, reader ownership and write pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr <= '0;
      r_owned <= 1'b0;
      r_ready_bank <= 1'b0;
      r_buffer_ready <= 1'b0;
    end else begin
      r_buffer_ready <= w_handoff;
      r_wr_ptr <= w_wr_ptr_nx;
      if (w_handoff) begin
        r_ready_bank <= r_wr_bank;
        r_wr_bank <= ~r_wr_bank;
        r_owned <= 1'b1;
      end else if (release_i) begin
        r_owned <= 1'b0;
      end
    end
  end
  // dropped-frame accounting; a drop coinciding with clear restarts the count at one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_drop <= '0;
    end else if (clear_overflow_i) begin
      r_overflow <= w_drop;
      r_drop <= DROP_W'(w_drop);
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop <= &r_drop ? r_drop : r_drop + DROP_W'(1);
    end
  end
  // read-side selection registers; they only move on a serviced read so rd_data_o holds otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_oob <= 1'b1;
      r_rd_ch <= '0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_oob <= w_oob;
        r_rd_ch <= w_oob ? '0 : rd_ch_i;
      end
    end
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_W-1:0] r_mem [2*DEPTH];
    logic [DATA_W-1:0] r_q;
    // per-channel RAM: capture write port and registered read from the owned bank
    always_ff @(posedge clk_i) begin
      if (w_we) r_mem[w_waddr] <= sample_i[c*DATA_W +: DATA_W];
      if (w_rd) r_q <= r_mem[{r_ready_bank, rd_addr_i}];
    end
    assign w_q[c*DATA_W +: DATA_W] = r_q;
  end
  assign rd_data_o = r_rd_oob ? '0 : w_q[32'(r_rd_ch)*DATA_W +: DATA_W];
  assign rd_valid_o = r_rd_valid;
  assign buffer_ready_o = r_buffer_ready;
  assign ready_bank_o = r_ready_bank;
  assign owned_o = r_owned;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop;
  assign wr_ptr_o = r_wr_ptr;
endmodule

// File: tb/tb_pingpong_mch_frame_buffer.sv
// tb_pingpong_mch_frame_buffer: frame-level model with per-cycle compare plus directed literal checks
module tb_pingpong_mch_frame_buffer;
  localparam int NC = 2, DW = 24, D = 8, AW = 3, CW = 2;
  logic clk = 1'b0, rst, enable, sv, rd_en, rel, clr;
  logic [NC*DW-1:0] sample;
  logic [CW-1:0] rd_ch;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic rd_valid, buffer_ready, ready_bank, owned, overflow;
  logic [15:0] drop_cnt;
  logic [AW-1:0] wr_ptr;
  int n_cmp = 0, n_err = 0, n_br = 0;
  logic [DW-1:0] m_mem [NC][2*D];
  logic [DW-1:0] m_rd;
  logic m_rv, m_br, m_ov, m_owned, m_wait;
  int m_wr_bank, m_ready_bank, m_wr_ptr, m_drop;

  pingpong_mch_frame_buffer #(.N_CH(NC), .DATA_W(DW), .DEPTH(D), .CH_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .sample_i(sample), .sample_valid_i(sv),
    .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .release_i(rel), .buffer_ready_o(buffer_ready), .ready_bank_o(ready_bank), .owned_o(owned),
    .overflow_o(overflow), .clear_overflow_i(clr), .drop_cnt_o(drop_cnt), .wr_ptr_o(wr_ptr));

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = '0; m_rv = 0; m_br = 0; m_ov = 0; m_owned = 0; m_wait = 0;
    m_wr_bank = 0; m_ready_bank = 0; m_wr_ptr = 0; m_drop = 0;
  endtask

  task automatic model_step();
    logic acc, drop, hand;
    acc = sv & enable; drop = 0; hand = 0;
    if (rd_en && m_owned) begin
      m_rv = 1;
      m_rd = (rd_ch >= NC) ? '0 : m_mem[rd_ch][m_ready_bank*D + int'(rd_addr)];
    end else m_rv = 0;
    if (!m_wait) begin
      if (acc) begin
        for (int c = 0; c < NC; c++) m_mem[c][m_wr_bank*D + m_wr_ptr] = sample[c*DW +: DW];
        if (m_wr_ptr < D-1) m_wr_ptr++;
        else if (!m_owned || rel) hand = 1;
        else m_wait = 1;
      end
      if (hand) m_wr_ptr = 0;
      else if (rel) m_owned = 0;
    end else if (rel) begin
      hand = 1; m_wait = 0; m_wr_ptr = 0;
      if (acc) begin
        for (int c = 0; c < NC; c++) m_mem[c][(1-m_wr_bank)*D] = sample[c*DW +: DW];
        m_wr_ptr = 1;
      end
    end else drop = acc;
    if (hand) begin
      m_ready_bank = m_wr_bank; m_wr_bank = 1 - m_wr_bank; m_owned = 1;
    end
    m_br = hand;
    if (clr) begin
      m_ov = drop; m_drop = drop ? 1 : 0;
    end else if (drop) begin
      m_ov = 1;
      if (m_drop < 65535) m_drop++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (buffer_ready === 1'b1) n_br++;
      cmp("buffer_ready", 64'(buffer_ready), 64'(m_br));
      cmp("ready_bank", 64'(ready_bank), 64'(m_ready_bank));
      cmp("owned", 64'(owned), 64'(m_owned));
      cmp("wr_ptr", 64'(wr_ptr), 64'(m_wr_ptr));
      cmp("overflow", 64'(overflow), 64'(m_ov));
      cmp("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      cmp("rd_valid", 64'(rd_valid), 64'(m_rv));
      cmp("rd_data", 64'(rd_data), 64'(m_rd));
    end
  end

  task automatic strobe(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic r = 1'b0, input logic c = 1'b0);
    sample = {b, a}; sv = 1; rel = r; clr = c;
    @(posedge clk); #1;
    sv = 0; rel = 0; clr = 0;
  endtask

  task automatic rd(input int ch, input int addr);
    rd_en = 1; rd_ch = CW'(ch); rd_addr = AW'(addr);
    @(posedge clk); #1;
    rd_en = 0;
  endtask

  task automatic idle(input logic r = 1'b0, input logic c = 1'b0);
    rel = r; clr = c;
    @(posedge clk); #1;
    rel = 0; clr = 0;
  endtask

  task automatic reset_checks(input string t);
    cmp({t, "_owned"}, 64'(owned), 0);
    cmp({t, "_wr_ptr"}, 64'(wr_ptr), 0);
    cmp({t, "_ready_bank"}, 64'(ready_bank), 0);
    cmp({t, "_buffer_ready"}, 64'(buffer_ready), 0);
    cmp({t, "_rd_valid"}, 64'(rd_valid), 0);
    cmp({t, "_rd_data"}, 64'(rd_data), 0);
    cmp({t, "_overflow"}, 64'(overflow), 0);
    cmp({t, "_drop_cnt"}, 64'(drop_cnt), 0);
  endtask

  initial begin
    model_reset();
    rst = 1; enable = 1; sv = 0; rd_en = 0; rel = 0; clr = 0; sample = '0; rd_ch = '0; rd_addr = '0;
    #23 rst = 0;
    @(posedge clk); #1;
    reset_checks("lit_reset");
    rd(0, 0);
    cmp("lit_rd_unowned_valid", 64'(rd_valid), 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        enable = 0;
        strobe(24'hDEAD00, 24'hDEAD01);
        enable = 1;
        cmp("lit_disabled_hold_wr_ptr", 64'(wr_ptr), 4);
      end
      strobe(24'(k), 24'(256 + k));
    end
    cmp("lit_first_handoff_pulse", 64'(buffer_ready), 1);
    cmp("lit_first_ready_bank", 64'(ready_bank), 0);
    cmp("lit_first_owned", 64'(owned), 1);
    cmp("lit_first_wr_ptr", 64'(wr_ptr), 0);
    idle();
    cmp("lit_pulse_one_cycle", 64'(buffer_ready), 0);
    rd(1, 5);
    cmp("lit_rd_ch1_a5_valid", 64'(rd_valid), 1);
    cmp("lit_rd_ch1_a5", 64'(rd_data), 64'h105);
    rd(0, 4);
    cmp("lit_rd_ch0_a4_not_disabled_sample", 64'(rd_data), 4);
    rd(3, 0);
    cmp("lit_rd_oob_data", 64'(rd_data), 0);
    cmp("lit_rd_oob_valid", 64'(rd_valid), 1);
    for (int k = 0; k < 8; k++) strobe(24'(512 + k), 24'(768 + k));
    cmp("lit_wait_wr_ptr", 64'(wr_ptr), 7);
    for (int k = 0; k < 3; k++) strobe(24'h999, 24'h999);
    cmp("lit_drop_overflow", 64'(overflow), 1);
    cmp("lit_drop_cnt3", 64'(drop_cnt), 3);
    cmp("lit_drop_wr_ptr", 64'(wr_ptr), 7);
    cmp("lit_single_pulse_count", 64'(n_br), 1);
    rd(0, 3);
    cmp("lit_bank0_intact", 64'(rd_data), 3);
    strobe(24'hAA, 24'hBB, 1'b1);
    cmp("lit_wait_release_pulse", 64'(buffer_ready), 1);
    cmp("lit_wait_release_bank", 64'(ready_bank), 1);
    cmp("lit_wait_release_wr_ptr", 64'(wr_ptr), 1);
    cmp("lit_wait_release_no_drop", 64'(drop_cnt), 3);
    rd(1, 7);
    cmp("lit_bank1_ch1_a7", 64'(rd_data), 64'h307);
    for (int k = 1; k < 8; k++) strobe(24'(1024 + k), 24'(1280 + k), k == 7);
    cmp("lit_direct_handoff_pulse", 64'(buffer_ready), 1);
    cmp("lit_direct_handoff_bank", 64'(ready_bank), 0);
    cmp("lit_direct_handoff_wr_ptr", 64'(wr_ptr), 0);
    cmp("lit_direct_handoff_drop", 64'(drop_cnt), 3);
    rd(0, 0);
    cmp("lit_frame0_aa", 64'(rd_data), 64'hAA);
    rd(1, 0);
    cmp("lit_frame0_bb", 64'(rd_data), 64'hBB);
    rd(0, 7);
    cmp("lit_bank0_a7", 64'(rd_data), 64'h407);
    idle(1'b0, 1'b1);
    cmp("lit_clear_overflow", 64'(overflow), 0);
    cmp("lit_clear_drop", 64'(drop_cnt), 0);
    for (int k = 0; k < 8; k++) strobe(24'(1536 + k), 24'(1536 + k));
    strobe(24'h777, 24'h777, 1'b0, 1'b1);
    cmp("lit_clear_with_drop_ov", 64'(overflow), 1);
    cmp("lit_clear_with_drop_cnt", 64'(drop_cnt), 1);
    idle(1'b1);
    cmp("lit_bare_release_bank", 64'(ready_bank), 1);
    cmp("lit_bare_release_wr_ptr", 64'(wr_ptr), 0);
    idle(1'b1);
    cmp("lit_fill_release_owned", 64'(owned), 0);
    rd(0, 0);
    cmp("lit_rd_after_release_valid", 64'(rd_valid), 0);
    for (int k = 0; k < 8; k++) strobe(24'(2048 + k), 24'(2304 + k));
    cmp("lit_unowned_handoff_bank", 64'(ready_bank), 0);
    for (int k = 0; k < 4; k++) strobe(24'h5A, 24'h5B);
    cmp("lit_midfill_wr_ptr", 64'(wr_ptr), 4);
    cmp("lit_midfill_owned", 64'(owned), 1);
    #2 rst = 1;
    #1 reset_checks("lit_async_reset");
    #4 rst = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) strobe(24'(3072 + k), 24'(3328 + k));
    cmp("lit_post_reset_pulse", 64'(buffer_ready), 1);
    cmp("lit_post_reset_bank", 64'(ready_bank), 0);
    cmp("lit_post_reset_owned", 64'(owned), 1);
    rd(1, 2);
    cmp("lit_post_reset_rd", 64'(rd_data), 64'hD02);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
